// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - converter power-up / fault / bypass sequencing controller
module pwr_seq_ctrl #(
    parameter int CHK_CYC  = 8000,
    parameter int RST_CYC  = 400,
    parameter int XFER_CYC = 4000,
    parameter int WDT_CYC  = 40000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic       rst,
    input  logic       bypass_cmd,
    input  logic       recv_done,
    input  logic [4:0] fault,
    output logic       pwm_en,
    output logic       chkflt,
    output logic       chkflt_over,
    output logic [3:0] igbt_rst,
    output logic       lockn,
    output logic       bypass_on,
    output logic [5:0] fault_code,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_RUN    = 3'd2,
        S_XFER   = 3'd3,
        S_BYPASS = 3'd4,
        S_FAULT  = 3'd5,
        S_RSTP   = 3'd6
    } state_t;

    localparam logic [15:0] CHK_END  = 16'(CHK_CYC - 1);
    localparam logic [15:0] RST_END  = 16'(RST_CYC - 1);
    localparam logic [15:0] XFER_END = 16'(XFER_CYC - 1);
    localparam logic [15:0] WDT_LIM  = 16'(WDT_CYC);

    state_t      state_q, state_d;
    logic [4:0]  fsync_s1, fsync;
    logic [15:0] phase_cnt, wdt_cnt;
    logic        wdt_trip, bypass_q, bypass_rise, flt_any;
    logic        pwm_en_d, chkflt_d, chkflt_over_d, lockn_d, bypass_on_d;
    logic [3:0]  igbt_rst_d;

    assign bypass_rise = bypass_cmd & ~bypass_q;
    assign flt_any     = (|fsync) | wdt_trip;
    assign state       = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsync_s1 <= '0;
            fsync    <= '0;
            bypass_q <= 1'b0;
            wdt_cnt  <= '0;
            wdt_trip <= 1'b0;
        end else begin
            fsync_s1 <= fault;
            fsync    <= fsync_s1;
            bypass_q <= bypass_cmd;
            // Counter stops at the limit; the trip flag then holds until the next frame.
            if (recv_done) begin
                wdt_cnt  <= '0;
                wdt_trip <= 1'b0;
            end else if (wdt_cnt != WDT_LIM) begin
                wdt_cnt  <= wdt_cnt + 16'd1;
                wdt_trip <= (wdt_cnt == WDT_LIM - 16'd1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start && !stop && !flt_any) state_d = S_CHECK;
            S_CHECK:  if (flt_any) state_d = S_FAULT;
                      else if (phase_cnt == CHK_END) state_d = S_RUN;
            S_RUN:    if (flt_any) state_d = S_FAULT;
                      else if (stop) state_d = S_IDLE;
                      else if (bypass_rise) state_d = S_XFER;
            S_XFER:   if (flt_any) state_d = S_FAULT;
                      else if (phase_cnt == XFER_END) state_d = S_BYPASS;
            S_BYPASS: if (!bypass_cmd || stop) state_d = S_IDLE;
            S_FAULT:  if (rst && fsync == 5'd0) state_d = S_RSTP;
            S_RSTP:   if (phase_cnt == RST_END) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state so they register together with it.
        pwm_en_d      = (state_d == S_RUN);
        chkflt_d      = (state_d == S_CHECK);
        chkflt_over_d = (state_q == S_CHECK) && (state_d == S_RUN);
        igbt_rst_d    = {4{state_d == S_RSTP}};
        lockn_d       = !((state_d == S_FAULT) || (state_d == S_RSTP));
        bypass_on_d   = (state_d == S_BYPASS);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            phase_cnt   <= '0;
            pwm_en      <= 1'b0;
            chkflt      <= 1'b0;
            chkflt_over <= 1'b0;
            igbt_rst    <= 4'h0;
            lockn       <= 1'b1;
            bypass_on   <= 1'b0;
            fault_code  <= 6'h00;
        end else begin
            state_q     <= state_d;
            pwm_en      <= pwm_en_d;
            chkflt      <= chkflt_d;
            chkflt_over <= chkflt_over_d;
            igbt_rst    <= igbt_rst_d;
            lockn       <= lockn_d;
            bypass_on   <= bypass_on_d;
            if (state_d != state_q)
                phase_cnt <= '0;
            else if (phase_cnt != 16'hFFFF)
                phase_cnt <= phase_cnt + 16'd1;
            if (state_q != S_FAULT && state_d == S_FAULT)
                fault_code <= {wdt_trip, fsync};
            else if (state_d == S_IDLE)
                fault_code <= 6'h00;
        end
    end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - directed vector bench for pwr_seq_ctrl
module tb_pwr_seq_ctrl;

    localparam int CHK  = 300;
    localparam int RSTC = 20;
    localparam int XFR  = 60;
    localparam int WDT  = 200;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0, stop = 1'b0, rst = 1'b0, bypass_cmd = 1'b0, recv_done = 1'b0;
    logic [4:0] fault = 5'd0;
    logic       pwm_en, chkflt, chkflt_over, lockn, bypass_on;
    logic [3:0] igbt_rst;
    logic [5:0] fault_code;
    logic [2:0] state;
    logic       feed_en = 1'b1;

    int checks = 0;
    int errors = 0;

    pwr_seq_ctrl #(.CHK_CYC(CHK), .RST_CYC(RSTC), .XFER_CYC(XFR), .WDT_CYC(WDT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .rst(rst),
        .bypass_cmd(bypass_cmd), .recv_done(recv_done), .fault(fault),
        .pwm_en(pwm_en), .chkflt(chkflt), .chkflt_over(chkflt_over), .igbt_rst(igbt_rst),
        .lockn(lockn), .bypass_on(bypass_on), .fault_code(fault_code), .state(state)
    );

    always #5 clk = ~clk;

    // Downlink frames every 50 cycles while enabled.
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            recv_done = feed_en && (cyc % 50 == 0);
        end
    end

    typedef struct {
        logic       start, stop, rst, byp;
        logic [4:0] flt;
        logic [2:0] st;
        logic       pwm, chk, lk, bon;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; rst = 0; bypass_cmd = 0; fault = 5'd0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string name);
        int n = 0;
        while (state !== s && n < limit) begin
            step();
            n++;
        end
        chk(name, 32'(state), 32'(s));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_pwm"}, 32'(pwm_en), 32'd0);
        chk({tag, "_chkflt"}, 32'(chkflt), 32'd0);
        chk({tag, "_over"}, 32'(chkflt_over), 32'd0);
        chk({tag, "_igbt"}, 32'(igbt_rst), 32'd0);
        chk({tag, "_lockn"}, 32'(lockn), 32'd1);
        chk({tag, "_bypass"}, 32'(bypass_on), 32'd0);
        chk({tag, "_code"}, 32'(fault_code), 32'd0);
    endtask

    initial begin
        int n;
        //            start stop rst byp flt    st   pwm chk lk bon
        tbl[0]  = '{0, 0, 0, 0, 5'd0, 3'd0, 0, 0, 1, 0};
        tbl[1]  = '{0, 0, 0, 1, 5'd0, 3'd0, 0, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 0, 5'd0, 3'd0, 0, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 5'd0, 3'd0, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 1, 0, 5'd0, 3'd0, 0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 5'd1, 3'd0, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 5'd1, 3'd0, 0, 0, 1, 0};
        tbl[7]  = '{1, 0, 0, 0, 5'd1, 3'd0, 0, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 5'd0, 3'd0, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 5'd0, 3'd0, 0, 0, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 5'd0, 3'd1, 0, 1, 1, 0};
        tbl[11] = '{1, 0, 0, 0, 5'd0, 3'd1, 0, 1, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start; stop = tbl[i].stop; rst = tbl[i].rst;
            bypass_cmd = tbl[i].byp; fault = tbl[i].flt;
            step();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_pwm", i), 32'(pwm_en), 32'(tbl[i].pwm));
            chk($sformatf("vec%0d_chkflt", i), 32'(chkflt), 32'(tbl[i].chk));
            chk($sformatf("vec%0d_lockn", i), 32'(lockn), 32'(tbl[i].lk));
            chk($sformatf("vec%0d_bypass", i), 32'(bypass_on), 32'(tbl[i].bon));
        end

        // Check window length, completion pulse, stop from RUN
        do_reset();
        pulse_start();
        n = 0;
        while (chkflt === 1'b1 && n < CHK + 50) begin
            step();
            n++;
        end
        chk("chk_window_len", 32'(n), 32'(CHK));
        chk("chk_over_pulse", 32'(chkflt_over), 32'd1);
        chk("run_pwm", 32'(pwm_en), 32'd1);
        chk("run_state", 32'(state), 32'd2);
        step();
        chk("chk_over_one_cycle", 32'(chkflt_over), 32'd0);
        stop = 1; step(); stop = 0;
        chk("stop_pwm", 32'(pwm_en), 32'd0);
        chk("stop_state", 32'(state), 32'd0);

        // Fault in RUN, reset attempts, RSTP pulse length
        do_reset();
        pulse_start();
        wait_state(3'd2, CHK + 50, "reach_run_b");
        fault = 5'b00100;
        step();
        step();
        chk("flt_pwm_edge2", 32'(pwm_en), 32'd1);
        step();
        chk("flt_pwm_edge3", 32'(pwm_en), 32'd0);
        chk("flt_state", 32'(state), 32'd5);
        chk("flt_lockn", 32'(lockn), 32'd0);
        chk("flt_code", 32'(fault_code), 32'h04);
        chk("flt_chkflt", 32'(chkflt), 32'd0);
        fault = 5'b10101;
        repeat (3) step();
        chk("flt_code_held", 32'(fault_code), 32'h04);
        rst = 1; step(); rst = 0;
        chk("rst_blocked", 32'(state), 32'd5);
        fault = 5'd0;
        repeat (3) step();
        rst = 1; step(); rst = 0;
        chk("rstp_state", 32'(state), 32'd6);
        n = 0;
        while (igbt_rst === 4'hF && n < RSTC + 50) begin
            step();
            n++;
        end
        chk("rstp_len", 32'(n), 32'(RSTC));
        chk("rstp_idle", 32'(state), 32'd0);
        chk("rstp_lockn", 32'(lockn), 32'd1);
        chk("rstp_code", 32'(fault_code), 32'd0);

        // Bypass transfer, watchdog and faults ignored in BYPASS
        do_reset();
        pulse_start();
        wait_state(3'd2, CHK + 50, "reach_run_c");
        bypass_cmd = 1;
        step();
        chk("xfer_state", 32'(state), 32'd3);
        chk("xfer_pwm", 32'(pwm_en), 32'd0);
        chk("xfer_bypass", 32'(bypass_on), 32'd0);
        n = 0;
        while (state === 3'd3 && n < XFR + 50) begin
            step();
            n++;
        end
        chk("xfer_len", 32'(n), 32'(XFR));
        chk("bypass_on", 32'(bypass_on), 32'd1);
        chk("bypass_state", 32'(state), 32'd4);
        chk("bypass_pwm", 32'(pwm_en), 32'd0);
        feed_en = 0;
        repeat (WDT + 40) step();
        fault = 5'b00010;
        repeat (4) step();
        chk("bypass_wdt_ignored", 32'(state), 32'd4);
        fault = 5'd0;
        bypass_cmd = 0;
        step();
        chk("bypass_off", 32'(bypass_on), 32'd0);
        chk("bypass_idle", 32'(state), 32'd0);
        feed_en = 1;

        // Watchdog trip during CHECK, start refused while tripped, async reset mid-CHECK
        feed_en = 0;
        do_reset();
        pulse_start();
        repeat (150) step();
        chk("wdt_not_yet", 32'(state), 32'd1);
        wait_state(3'd5, 200, "wdt_fault");
        chk("wdt_code", 32'(fault_code), 32'h20);
        chk("wdt_lockn", 32'(lockn), 32'd0);
        rst = 1; step(); rst = 0;
        wait_state(3'd0, RSTC + 10, "wdt_recover");
        pulse_start();
        chk("wdt_start_refused", 32'(state), 32'd0);
        feed_en = 1;
        repeat (60) step();
        pulse_start();
        chk("restart_check", 32'(state), 32'd1);
        repeat (10) step();
        rstn = 1'b0;
        #1;
        check_reset_vals("async_rst");
        step();
        rstn = 1'b1;
        step();
        chk("post_rst_idle", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
